// File: rtl/tile_map_ctrl.sv
// rtl/tile_map_ctrl.sv - 8x8 tile map with level loader, draw/game arbitration and breakable tracking
// Draw lookups win arbitration unless a game request has starved for MAX_WAIT cycles.
module tile_map_ctrl #(
  parameter int MAX_WAIT = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       load_start,
  input  logic       load_level,
  output logic       busy,
  input  logic       draw_req,
  input  logic [2:0] draw_x,
  input  logic [2:0] draw_y,
  output logic [1:0] draw_type,
  output logic       draw_valid,
  input  logic       gl_req,
  input  logic [1:0] gl_op,
  input  logic [2:0] gl_x,
  input  logic [2:0] gl_y,
  input  logic [1:0] gl_wdata,
  output logic       gl_ack,
  output logic [1:0] gl_rdata,
  output logic [6:0] breakable_cnt,
  output logic       level_clear
);

  localparam logic [3:0] MAX_WAIT_C = 4'(MAX_WAIT);

  localparam logic [1:0] T_EMPTY     = 2'b00;
  localparam logic [1:0] T_BREAKABLE = 2'b01;
  localparam logic [1:0] T_SOLID     = 2'b10;
  localparam logic [1:0] T_BONUS     = 2'b11;

  localparam logic [1:0] OP_WRITE = 2'b01;
  localparam logic [1:0] OP_HIT   = 2'b10;

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_RUN
  } state_t;

  state_t     state_q;
  logic [5:0] idx_q;
  logic       level_q;
  logic [3:0] wait_q;
  logic [1:0] map_q [64];

  logic       busy_q;
  logic [1:0] draw_type_q;
  logic       draw_valid_q;
  logic       gl_ack_q;
  logic [1:0] gl_rdata_q;
  logic [6:0] cnt_q;
  logic       level_clear_q;

  logic [5:0] gl_idx;
  logic [5:0] draw_idx;
  logic [1:0] gl_old;
  logic [1:0] gl_new_d;
  logic [6:0] cnt_gl_d;
  logic [1:0] load_cell_d;
  logic       grant;

  // Level patterns, indexed row-major: y = idx[5:3], x = idx[2:0].
  function automatic logic [1:0] level_cell(input logic lvl, input logic [5:0] idx);
    logic [2:0] x;
    logic [2:0] y;
    x = idx[2:0];
    y = idx[5:3];
    if (!lvl) begin
      return (y == 3'd7 && x <= 3'd5) ? T_BREAKABLE : T_EMPTY;
    end
    if (y == 3'd7 || y == 3'd6) return T_BREAKABLE;
    if (y == 3'd4 && x >= 3'd2 && x <= 3'd5) return T_SOLID;
    if (y == 3'd2 && x == 3'd3) return T_BONUS;
    return T_EMPTY;
  endfunction

  assign gl_idx      = {gl_y, gl_x};
  assign draw_idx    = {draw_y, draw_x};
  assign gl_old      = map_q[gl_idx];
  assign load_cell_d = level_cell(level_q, idx_q);

  // The ack cycle is excluded so a requester still holding gl_req is not granted twice.
  assign grant = (state_q == S_RUN) && gl_req && !gl_ack_q && !load_start &&
                 (!draw_req || wait_q == MAX_WAIT_C);

  always_comb begin
    gl_new_d = gl_old;
    case (gl_op)
      OP_WRITE: gl_new_d = gl_wdata;
      OP_HIT: begin
        if (gl_old == T_BREAKABLE)  gl_new_d = T_EMPTY;
        else if (gl_old == T_BONUS) gl_new_d = T_BREAKABLE;
      end
      default: ;
    endcase
  end

  always_comb begin
    cnt_gl_d = cnt_q;
    if (gl_old == T_BREAKABLE && gl_new_d != T_BREAKABLE)
      cnt_gl_d = cnt_q - 7'd1;
    else if (gl_old != T_BREAKABLE && gl_new_d == T_BREAKABLE)
      cnt_gl_d = cnt_q + 7'd1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= S_IDLE;
      idx_q         <= 6'd0;
      level_q       <= 1'b0;
      wait_q        <= 4'd0;
      busy_q        <= 1'b0;
      draw_type_q   <= T_EMPTY;
      draw_valid_q  <= 1'b0;
      gl_ack_q      <= 1'b0;
      gl_rdata_q    <= 2'b00;
      cnt_q         <= 7'd0;
      level_clear_q <= 1'b0;
      for (int i = 0; i < 64; i++) map_q[i] <= T_EMPTY;
    end else begin
      gl_ack_q      <= grant;
      level_clear_q <= 1'b0;
      draw_valid_q  <= draw_req && !grant;
      draw_type_q   <= (state_q == S_RUN && draw_req && !grant) ? map_q[draw_idx] : T_EMPTY;

      if (grant || state_q != S_RUN || !gl_req)
        wait_q <= 4'd0;
      else if (!gl_ack_q && wait_q != MAX_WAIT_C)
        wait_q <= wait_q + 4'd1;

      if (grant) begin
        gl_rdata_q      <= gl_old;
        map_q[gl_idx]   <= gl_new_d;
        cnt_q           <= cnt_gl_d;
        level_clear_q   <= (cnt_q == 7'd1) && (cnt_gl_d == 7'd0);
      end

      if (load_start) begin
        state_q <= S_LOAD;
        idx_q   <= 6'd0;
        level_q <= load_level;
        cnt_q   <= 7'd0;
        busy_q  <= 1'b1;
      end else begin
        case (state_q)
          S_LOAD: begin
            map_q[idx_q] <= load_cell_d;
            cnt_q        <= cnt_q + {6'd0, load_cell_d == T_BREAKABLE};
            idx_q        <= idx_q + 6'd1;
            if (idx_q == 6'd63) begin
              state_q <= S_RUN;
              busy_q  <= 1'b0;
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign busy          = busy_q;
  assign draw_type     = draw_type_q;
  assign draw_valid    = draw_valid_q;
  assign gl_ack        = gl_ack_q;
  assign gl_rdata      = gl_rdata_q;
  assign breakable_cnt = cnt_q;
  assign level_clear   = level_clear_q;

endmodule

// File: tb/tb_tile_map_ctrl.sv
// tb/tb_tile_map_ctrl.sv - directed and randomized bench for tile_map_ctrl
// Reference map is a plain array updated from the tile rules; counts are recomputed by scanning it.
module tb_tile_map_ctrl;

  localparam int MAX_WAIT = 4;

  logic       clk = 1'b0;
  logic       reset;
  logic       load_start;
  logic       load_level;
  logic       busy;
  logic       draw_req;
  logic [2:0] draw_x;
  logic [2:0] draw_y;
  logic [1:0] draw_type;
  logic       draw_valid;
  logic       gl_req;
  logic [1:0] gl_op;
  logic [2:0] gl_x;
  logic [2:0] gl_y;
  logic [1:0] gl_wdata;
  logic       gl_ack;
  logic [1:0] gl_rdata;
  logic [6:0] breakable_cnt;
  logic       level_clear;

  tile_map_ctrl #(.MAX_WAIT(MAX_WAIT)) dut (
    .clk          (clk),
    .reset        (reset),
    .load_start   (load_start),
    .load_level   (load_level),
    .busy         (busy),
    .draw_req     (draw_req),
    .draw_x       (draw_x),
    .draw_y       (draw_y),
    .draw_type    (draw_type),
    .draw_valid   (draw_valid),
    .gl_req       (gl_req),
    .gl_op        (gl_op),
    .gl_x         (gl_x),
    .gl_y         (gl_y),
    .gl_wdata     (gl_wdata),
    .gl_ack       (gl_ack),
    .gl_rdata     (gl_rdata),
    .breakable_cnt(breakable_cnt),
    .level_clear  (level_clear)
  );

  always #5 clk = ~clk;

  int         vectors = 0;
  int         miscompares = 0;
  logic [1:0] model [64];
  bit         in_run = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic int model_cnt();
    int n = 0;
    for (int i = 0; i < 64; i++) if (model[i] == 2'b01) n++;
    return n;
  endfunction

  function automatic logic [1:0] pattern(input int lvl, input int x, input int y);
    if (lvl == 0) return (y == 7 && x <= 5) ? 2'b01 : 2'b00;
    if (y == 7 || y == 6) return 2'b01;
    if (y == 4 && x >= 2 && x <= 5) return 2'b10;
    if (x == 3 && y == 2) return 2'b11;
    return 2'b00;
  endfunction

  task automatic count_busy(input string tag);
    int n = 0;
    while (busy === 1'b1 && n < 200) begin
      n++;
      step();
    end
    check(tag, n, 64);
  endtask

  task automatic do_load(input int lvl);
    load_start = 1'b1;
    load_level = lvl[0];
    step();
    load_start = 1'b0;
    count_busy("busy_cycles");
    for (int i = 0; i < 64; i++) model[i] = pattern(lvl, i % 8, i / 8);
    in_run = 1'b1;
    check("cnt_after_load", breakable_cnt, model_cnt());
  endtask

  task automatic draw_chk(input int x, input int y);
    draw_req = 1'b1;
    draw_x   = 3'(x);
    draw_y   = 3'(y);
    step();
    draw_req = 1'b0;
    check("draw_valid", draw_valid, 1);
    check("draw_type", draw_type, in_run ? model[y * 8 + x] : 2'b00);
  endtask

  task automatic gl_do(input int op, input int x, input int y, input int wd,
                       input bit hold_draw, input int dx, input int dy);
    int         lat = 0;
    bit         got = 1'b0;
    int         idx = y * 8 + x;
    int         cprev;
    logic [1:0] old;
    logic [1:0] nw;
    old = model[idx];
    nw  = old;
    if (op == 1) nw = 2'(wd);
    else if (op == 2) nw = (old == 2'b01) ? 2'b00 : (old == 2'b11) ? 2'b01 : old;
    cprev    = model_cnt();
    gl_req   = 1'b1;
    gl_op    = 2'(op);
    gl_x     = 3'(x);
    gl_y     = 3'(y);
    gl_wdata = 2'(wd);
    draw_req = hold_draw;
    draw_x   = 3'(dx);
    draw_y   = 3'(dy);
    while (!got && lat < 40) begin
      step();
      lat++;
      if (gl_ack === 1'b1) got = 1'b1;
      else if (hold_draw) begin
        check("draw_wait_valid", draw_valid, 1);
        check("draw_wait_type", draw_type, model[dy * 8 + dx]);
      end
    end
    check("gl_ack_seen", got, 1);
    check("gl_latency", lat, hold_draw ? MAX_WAIT + 1 : 1);
    check("gl_rdata", gl_rdata, old);
    model[idx] = nw;
    check("breakable_cnt", breakable_cnt, model_cnt());
    check("level_clear", level_clear, (cprev == 1 && model_cnt() == 0));
    if (hold_draw) check("draw_lost", draw_valid, 0);
    gl_req = 1'b0;
    step();
    if (hold_draw) begin
      check("draw_after_ack_valid", draw_valid, 1);
      check("draw_after_ack_type", draw_type, model[dy * 8 + dx]);
    end
    check("ack_single", gl_ack, 0);
    check("level_clear_single", level_clear, 0);
    draw_req = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    int acks;
    reset      = 1'b1;
    load_start = 1'b0;
    load_level = 1'b0;
    draw_req   = 1'b0;
    draw_x     = 3'd0;
    draw_y     = 3'd0;
    gl_req     = 1'b0;
    gl_op      = 2'b00;
    gl_x       = 3'd0;
    gl_y       = 3'd0;
    gl_wdata   = 2'b00;
    for (int i = 0; i < 64; i++) model[i] = 2'b00;
    #12;
    check("rst_busy", busy, 0);
    check("rst_draw_valid", draw_valid, 0);
    check("rst_gl_ack", gl_ack, 0);
    check("rst_cnt", breakable_cnt, 0);
    check("rst_level_clear", level_clear, 0);
    step();
    reset = 1'b0;
    step();
    draw_chk(3, 3);

    // 1: level 0 load
    do_load(0);
    check("lvl0_cnt", breakable_cnt, 6);
    draw_chk(2, 7);
    draw_chk(6, 7);

    // 2: HIT with draw idle, then update visible to the next draw
    gl_do(2, 0, 7, 0, 1'b0, 0, 0);
    check("hit_cnt5", breakable_cnt, 5);
    draw_chk(0, 7);

    // 3: draw held high starves then loses to a pending READ
    gl_do(0, 1, 7, 0, 1'b1, 2, 7);

    // 4: clear level 0
    do_load(0);
    for (int x = 0; x < 6; x++) gl_do(2, x, 7, 0, 1'b0, 0, 0);
    check("clear_cnt0", breakable_cnt, 0);

    // 5: level 1 bonus, write and solid hit
    do_load(1);
    check("lvl1_cnt", breakable_cnt, 16);
    gl_do(2, 3, 2, 0, 1'b0, 0, 0);
    check("bonus_cnt17", breakable_cnt, 17);
    draw_chk(3, 2);
    gl_do(1, 0, 7, 2, 1'b0, 0, 0);
    check("write_cnt16", breakable_cnt, 16);
    gl_do(2, 2, 4, 0, 1'b1, 2, 4);
    draw_chk(2, 4);

    // randomized ops on the bottom rows of level 0
    do_load(0);
    for (int k = 0; k < 120; k++) begin
      int  x = $urandom_range(0, 7);
      int  y = $urandom_range(6, 7);
      bit  h = 1'($urandom_range(0, 1));
      bit  same = 1'($urandom_range(0, 1));
      int  dx = same ? x : $urandom_range(0, 7);
      int  dy = same ? y : $urandom_range(0, 7);
      gl_do($urandom_range(0, 3), x, y, $urandom_range(0, 3), h, dx, dy);
      if ($urandom_range(0, 3) == 0) draw_chk($urandom_range(0, 7), $urandom_range(0, 7));
    end

    // 6: restart mid-load, draw in LOAD returns empty
    load_start = 1'b1;
    load_level = 1'b1;
    step();
    load_start = 1'b0;
    in_run   = 1'b0;
    draw_req = 1'b1;
    draw_x   = 3'd2;
    draw_y   = 3'd7;
    for (int i = 0; i < 30; i++) step();
    check("load_busy_mid", busy, 1);
    check("load_draw_valid", draw_valid, 1);
    check("load_draw_type", draw_type, 0);
    draw_req   = 1'b0;
    load_start = 1'b1;
    load_level = 1'b0;
    step();
    load_start = 1'b0;
    count_busy("restart_busy_cycles");
    for (int i = 0; i < 64; i++) model[i] = pattern(0, i % 8, i / 8);
    in_run = 1'b1;
    check("restart_relatch_cnt", breakable_cnt, 6);

    // async reset while a starved request is pending
    gl_req   = 1'b1;
    gl_op    = 2'b10;
    gl_x     = 3'd1;
    gl_y     = 3'd7;
    draw_req = 1'b1;
    step();
    step();
    check("pending_no_ack", gl_ack, 0);
    #2 reset = 1'b1;
    #1;
    check("arst_busy", busy, 0);
    check("arst_draw_valid", draw_valid, 0);
    check("arst_draw_type", draw_type, 0);
    check("arst_gl_ack", gl_ack, 0);
    check("arst_gl_rdata", gl_rdata, 0);
    check("arst_cnt", breakable_cnt, 0);
    check("arst_level_clear", level_clear, 0);
    draw_req = 1'b0;
    step();
    step();
    reset = 1'b0;
    for (int i = 0; i < 64; i++) model[i] = 2'b00;
    in_run = 1'b0;
    acks = 0;
    for (int i = 0; i < 8; i++) begin
      step();
      if (gl_ack === 1'b1) acks++;
    end
    check("idle_no_ack", acks, 0);
    gl_req = 1'b0;
    step();
    draw_chk(2, 7);
    check("idle_cnt", breakable_cnt, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
